// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the processor memory path.
package mips_pkg;

    localparam int DEF_DW         = 32;
    localparam int DEF_AW         = 32;
    localparam int DEF_LATENCY    = 2;
    localparam int DEF_STREAK_MAX = 3;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_prio.sv
// Fetch/data priority select; data wins unless fetch has waited through STREAK_MAX data grants.
module arb_prio
    import mips_pkg::*;
#(
    parameter int STREAK_MAX = DEF_STREAK_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_dm_req,
    input  logic i_grant,
    output logic o_grant_dm
);

    localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

    logic [SW-1:0] r_streak;
    logic          w_if_turn;

    assign w_if_turn  = i_if_req && (r_streak == SW'(STREAK_MAX));
    assign o_grant_dm = i_dm_req && !w_if_turn;

    // Only data grants that actually held off a waiting fetch extend the streak.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (i_grant) begin
            if (o_grant_dm && i_if_req) begin
                if (r_streak != SW'(STREAK_MAX))
                    r_streak <= r_streak + 1'b1;
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int STREAK_MAX = DEF_STREAK_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          if_stall,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t       r_state, w_state_nxt;
    owner_t           r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_we;
    logic [DW-1:0]    r_if_rdata, r_dm_rdata;
    logic             r_if_valid, r_dm_valid;
    logic             w_grant, w_grant_dm;

    arb_prio #(.STREAK_MAX(STREAK_MAX)) u_prio (
        .clk       (clk),
        .rst       (rst),
        .i_if_req  (if_req),
        .i_dm_req  (dm_req),
        .i_grant   (w_grant),
        .o_grant_dm(w_grant_dm)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: if (if_req || dm_req) begin
                w_grant     = 1'b1;
                w_state_nxt = S_BUSY;
            end
            S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner    <= OWN_IF;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            if (w_grant) begin
                r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
                r_addr  <= w_grant_dm ? dm_addr : if_addr;
                r_we    <= w_grant_dm && dm_we;
                r_wdata <= w_grant_dm ? dm_wdata : '0;
                r_cnt   <= CNT_W'(LATENCY - 1);
            end else if (r_state == S_BUSY) begin
                if (r_cnt == '0) begin
                    // Valid registers are set on the way into DONE so they are high exactly there.
                    if (r_owner == OWN_IF) begin
                        r_if_rdata <= mem_rdata;
                        r_if_valid <= 1'b1;
                    end else begin
                        if (!r_we) r_dm_rdata <= mem_rdata;
                        r_dm_valid <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign mem_en    = (r_state == S_BUSY);
    assign mem_we    = (r_state == S_BUSY) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_valid  = r_if_valid;
    assign dm_valid  = r_dm_valid;
    assign if_stall  = if_req && !r_if_valid;
    assign dm_stall  = dm_req && !r_dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small behavioural memory (LATENCY=2, STREAK_MAX=3).
module tb_mem_arbiter;

    logic        clk, rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, dm_valid, if_stall, dm_stall, mem_en, mem_we;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        own;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_chk, n_fail;
    int          cyc, if_left, dm_left, n_we;
    logic [31:0] last_addr, last_wdata, exp_dm;

    mem_arbiter #(.DW(32), .AW(32), .LATENCY(2), .STREAK_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .if_stall(if_stall), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic own, input logic [31:0] data, input int c);
        exp_t e;
        e.own  = own;
        e.data = data;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Drive requests on a falling edge; that cycle counts as cycle 1.
    task automatic start(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input int nif, input int ndm);
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dd;
        if_left  = nif;
        dm_left  = ndm;
        cyc      = 1;
    endtask

    task automatic wait_done(input int max_cyc);
        exp_t e;
        int   t;
        t    = 0;
        n_we = 0;
        while ((if_left > 0 || dm_left > 0) && t < max_cyc) begin
            @(negedge clk);
            cyc++;
            t++;
            if (mem_en) last_addr = mem_addr;
            if (mem_en && mem_we) begin
                n_we++;
                last_wdata = mem_wdata;
            end
            if (if_valid || dm_valid) begin
                chk("valid_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("owner", dm_valid, e.own);
                    chk("rdata", dm_valid ? dm_rdata : if_rdata, e.data);
                    chk("valid_cycle", cyc, e.cyc);
                    chk("en_in_done", mem_en, 0);
                    chk("own_stall", dm_valid ? dm_stall : if_stall, 0);
                    chk("other_stall", dm_valid ? if_stall : dm_stall, dm_valid ? if_req : dm_req);
                end
                if (if_valid) begin
                    if_left--;
                    if (if_left <= 0) if_req = 1'b0;
                end
                if (dm_valid) begin
                    dm_left--;
                    if (dm_left <= 0) dm_req = 1'b0;
                end
            end
        end
        chk("pending", if_left + dm_left, 0);
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
        mem[16] = 32'h8C01_0004;
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        exp_dm = '0;

        // Reset held with both requests up
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_valids", {if_valid, dm_valid}, 0);
        chk("rst_stalls", {if_stall, dm_stall}, 2'b11);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", mem_en, 0);

        // Lone fetch
        push(1'b0, mem[16], 4);
        start(1'b1, 32'h40, 1'b0, 1'b0, 0, 0, 1, 0);
        wait_done(40);
        chk("fetch_data", if_rdata, 32'h8C01_0004);
        chk("fetch_addr", last_addr, 32'h40);

        // Collision: data load first, then fetch
        push(1'b1, mem[64], 4);
        push(1'b0, mem[17], 8);
        exp_dm = mem[64];
        start(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 0, 1, 1);
        wait_done(40);

        // Starvation: three data grants, then fetch, then data again
        for (int k = 0; k < 3; k++) push(1'b1, mem[65], 4 + 4 * k);
        push(1'b0, mem[18], 16);
        push(1'b1, mem[65], 20);
        exp_dm = mem[65];
        start(1'b1, 32'h48, 1'b1, 1'b0, 32'h104, 0, 1, 4);
        wait_done(60);

        // Store leaves dm_rdata untouched
        push(1'b1, exp_dm, 4);
        start(1'b0, 0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1);
        wait_done(40);
        chk("st_we_cycles", n_we, 2);
        chk("st_addr", last_addr, 32'h10);
        chk("st_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("st_mem", mem[4], 32'hDEAD_BEEF);

        // Load back the stored word
        push(1'b1, 32'hDEAD_BEEF, 4);
        start(1'b0, 0, 1'b1, 1'b0, 32'h10, 0, 0, 1);
        wait_done(40);

        // Reset in the first BUSY cycle aborts the fetch
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        chk("abort_busy_en", mem_en, 1);
        rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_if_rdata", if_rdata, 0);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_quiet", {if_valid, dm_valid, mem_en}, 0);
        end

        // Fetch after the abort completes normally
        push(1'b0, mem[17], 4);
        start(1'b1, 32'h44, 1'b0, 1'b0, 0, 0, 1, 0);
        wait_done(40);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DW, 32, data width of all data buses.
REQ-002 Parameter: AW, 32, address width.
REQ-003 Parameter: LATENCY, 2, memory access cycles (legal range 1..15).
REQ-004 Parameter: STREAK_MAX, 3, max consecutive MEM grants while IF waits.
REQ-005 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-006 Port: rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets).
REQ-007 Port: if_req, if_addr  in  1/AW  instruction-fetch read request and address.
REQ-008 Port: dm_req, dm_we, dm_addr, dm_wdata  in  1/1/AW/DW  data-stage request, write enable, address, write data.
REQ-009 Port: if_rdata, if_valid  out  DW/1  fetch data plus one-cycle completion pulse.
REQ-010 Port: dm_rdata, dm_valid  out  DW/1  load data plus one-cycle completion pulse.
REQ-011 Port: if_stall, dm_stall  out  1/1  pipeline freeze requests to IF and MEM stages.
REQ-012 Port: mem_en, mem_we, mem_addr, mem_wdata  out  1/1/AW/DW  single-port memory command.
REQ-013 Port: mem_rdata  in  DW  memory read data, valid in final BUSY cycle.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 In IDLE with any req high, the block SHALL grant one requester, latch its addr/we/wdata and owner, load cnt=LATENCY-1, and go to BUSY.
REQ-016 Priority SHALL be dm over if, except if_req wins when streak==STREAK_MAX and if_req is high.
REQ-017 streak SHALL increment (saturating at STREAK_MAX) on a dm grant while if_req is high, and clear on any if grant or any grant made with if_req low.
REQ-018 In BUSY, mem_en=1 and mem_addr/mem_we/mem_wdata SHALL equal the latched values; cnt decrements each cycle.
REQ-019 In BUSY with cnt==0, the block SHALL register mem_rdata into the owner's rdata register and go to DONE.
REQ-020 In DONE, the owner's valid SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-021 Latency SHALL be exactly LATENCY+2 cycles from the req-sampled edge to the valid pulse; throughput SHALL be one access per LATENCY+2 cycles.
REQ-022 rdata registers SHALL hold their value until overwritten by the same owner; writes SHALL not update dm_rdata.
REQ-023 x_stall SHALL equal x_req AND NOT x_valid (combinational); a requester SHALL hold req/addr/data stable until its valid pulse.
REQ-024 A req dropped before its grant SHALL be ignored; a req dropped after grant SHALL not abort the access.
REQ-025 Simultaneous if_req and dm_req in IDLE SHALL resolve per REQ-016 and SHALL keep the loser stalled.
REQ-026 mem_en SHALL be 0 in IDLE and DONE.

Reset
REQ-027 On rst=0: state=IDLE, cnt=0, streak=0, owner=IF, and latched addr/wdata/we=0.
REQ-028 On rst=0: if_rdata=0, dm_rdata=0, all valid/mem_en/mem_we=0.
REQ-029 Reset during BUSY SHALL abort the access without a valid pulse, and mem_en SHALL be 0 in the following cycle.

Structure
REQ-030 The state encoding, owner encoding and default widths SHALL live in a shared package (mips_pkg) used by the processor top.
REQ-031 The priority/streak logic SHALL be one sub-module, arb_prio, which is combinational apart from the streak register.
REQ-032 The top-level processor SHALL instantiate mem_arbiter between its IF and MEM stages and a single-port memory.

Verification
REQ-033 Reset: hold rst=0 for 2 cycles with both reqs high -> mem_en=0, valids=0, both stalls=1, rdata=0.
REQ-034 Lone fetch: if_req=1, addr 0x40, memory returns 0x8C010004 -> if_valid pulses at edge 4 (LATENCY=2), if_rdata=0x8C010004, if_stall drops that cycle.
REQ-035 Collision: if_req and dm_req (load 0x100) both high -> dm served first, then if; dm_valid at cycle 4, if_valid at cycle 8.
REQ-036 Starvation: if_req held high, dm_req re-raised every access -> the 4th grant goes to IF (STREAK_MAX=3).
REQ-037 Store: dm_we=1, addr 0x10, wdata 0xDEADBEEF -> mem_we=1 for 2 BUSY cycles, dm_valid pulse, dm_rdata unchanged.
REQ-038 Mid-access reset: rst=0 in the first BUSY cycle -> no valid pulse, IDLE next, a later fetch completes normally.
